uart_mult_frame: RTL and testbench

//  Command engine between the UART receiver and UART transmitter inside uart_spi_top.

---
 rtl/uart_mult_frame_if.sv | 24 ++
 rtl/uart_mult_frame.sv | 144 ++++++++++++++
 tb/tb_uart_mult_frame.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_mult_frame_if.sv
// Byte-stream bundle between the UART RX/TX and the multiply engine.
// slave: engine side (rx in, tx out, status out); master: the peer side.
interface uart_mult_frame_if #(
    parameter int DATA_W = 8
);
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              tx_ready;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              busy;
    logic              timeout;
    logic              overrun;

    modport slave (
        input  rx_valid, rx_data, tx_ready,
        output tx_valid, tx_data, busy, timeout, overrun
    );

    modport master (
        output rx_valid, rx_data, tx_ready,
        input  tx_valid, tx_data, busy, timeout, overrun
    );
endinterface

// File: rtl/uart_mult_frame.sv
// Two-byte multiply command engine: takes A, B from UART RX, shift-add
// multiplies, returns the product high byte first on UART TX.
// Ports: clk, reset (async, active-low), bus (slave: rx_valid/rx_data in,
// tx_ready in, tx_valid/tx_data out, busy/timeout/overrun status out).
module uart_mult_frame #(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic             clk,
    input  logic             reset,
    uart_mult_frame_if.slave bus
);
    localparam int PW = 2 * DATA_W;
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0] BIT_LAST = CW'(DATA_W - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GET_B   = 3'd1;
    localparam logic [2:0] S_MULT    = 3'd2;
    localparam logic [2:0] S_SEND_HI = 3'd3;
    localparam logic [2:0] S_SEND_LO = 3'd4;

    logic [2:0]        state_q,    state_d;
    logic [PW-1:0]     mcand_q,    mcand_d;
    logic [DATA_W-1:0] mplier_q,   mplier_d;
    logic [PW-1:0]     acc_q,      acc_d;
    logic [CW-1:0]     bit_cnt_q,  bit_cnt_d;
    logic [TW-1:0]     to_cnt_q,   to_cnt_d;
    logic              tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0] tx_data_q,  tx_data_d;
    logic              timeout_q,  timeout_d;
    logic              overrun_q,  overrun_d;

    // Accumulator after the current shift-add step.
    logic [PW-1:0] acc_step;
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        bit_cnt_d  = bit_cnt_q;
        to_cnt_d   = to_cnt_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        timeout_d  = 1'b0;
        overrun_d  = overrun_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    mcand_d  = {{DATA_W{1'b0}}, bus.rx_data};
                    to_cnt_d = '0;
                    state_d  = S_GET_B;
                end
            end
            S_GET_B: begin
                // A byte in the terminal-count cycle still completes the frame.
                if (bus.rx_valid) begin
                    mplier_d  = bus.rx_data;
                    acc_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = S_MULT;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    mcand_d   = '0;
                    state_d   = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_MULT: begin
                acc_d     = acc_step;
                mcand_d   = mcand_q << 1;
                mplier_d  = mplier_q >> 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BIT_LAST) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = acc_step[PW-1:DATA_W];
                    state_d    = S_SEND_HI;
                end
            end
            S_SEND_HI: begin
                if (bus.tx_ready) begin
                    tx_data_d = acc_q[DATA_W-1:0];
                    state_d   = S_SEND_LO;
                end
            end
            S_SEND_LO: begin
                if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

        // Bytes landing while the engine is committed are dropped but flagged.
        if (bus.rx_valid &&
            (state_q == S_MULT || state_q == S_SEND_HI ||
             state_q == S_SEND_LO)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            bit_cnt_q  <= '0;
            to_cnt_q   <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            bit_cnt_q  <= bit_cnt_d;
            to_cnt_q   <= to_cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.timeout  = timeout_q;
    assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_uart_mult_frame.sv
// Bench for uart_mult_frame: fixed vectors, random frames against a
// product model, and hand-built timeout / overrun / reset sequences.
module tb_uart_mult_frame;
    localparam int W  = 8;
    localparam int TO = 100;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;
    int   to_pulses;

    uart_mult_frame_if #(.DATA_W(W)) bus ();

    uart_mult_frame #(
        .DATA_W     (W),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.timeout === 1'b1) to_pulses++;
    end

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [W-1:0] d);
        bus.rx_valid = 1'b1;
        bus.rx_data  = d;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    // Runs one frame from a negedge; ends on the negedge after the low byte.
    task automatic frame(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp, input int gap,
                         input int hold, input int pct, input bit inject,
                         input string tag);
        int lat, got, budget, bad, t0, h;
        bit pend, rdy;
        logic [W-1:0] pdata;
        logic [W-1:0] bytes [2];
        t0 = to_pulses;
        h  = hold;
        send_byte(a);
        for (int i = 0; i < gap; i++) @(negedge clk);
        send_byte(b);
        lat = 1;
        while (bus.tx_valid !== 1'b1 && lat < 40) begin
            bus.rx_valid = inject && (lat == 3);
            bus.rx_data  = 8'h77;
            @(negedge clk);
            lat++;
        end
        bus.rx_valid = 1'b0;
        chk({tag, " latency"}, lat, W + 1);
        got = 0; budget = 0; bad = 0; pend = 0; pdata = '0;
        bytes[0] = '0; bytes[1] = '0;
        while (got < 2 && budget < 300) begin
            if (pend && (bus.tx_valid !== 1'b1 || bus.tx_data !== pdata))
                bad++;
            if (bus.tx_valid === 1'b1) begin
                rdy = (h > 0) ? 1'b0 : ($urandom_range(0, 99) < pct);
                if (h > 0) h--;
                bus.tx_ready = rdy;
                if (rdy) begin
                    bytes[got] = bus.tx_data;
                    got++;
                    pend = 1'b0;
                end else begin
                    pend  = 1'b1;
                    pdata = bus.tx_data;
                end
            end else begin
                bus.tx_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            budget++;
        end
        bus.tx_ready = 1'b0;
        chk({tag, " bytes"}, got, 2);
        chk({tag, " hi"}, int'(bytes[0]), int'(exp[2*W-1:W]));
        chk({tag, " lo"}, int'(bytes[1]), int'(exp[W-1:0]));
        chk({tag, " stable"}, bad, 0);
        chk({tag, " txv_end"}, int'(bus.tx_valid), 0);
        chk({tag, " busy_end"}, int'(bus.busy), 0);
        chk({tag, " no_timeout"}, to_pulses - t0, 0);
    endtask

    vec_t vt [6];

    initial begin
        logic [W-1:0] ra, rb;
        int t0, cnt;
        pass_cnt = 0; total_cnt = 0; to_pulses = 0;
        vt[0] = '{8'h0C, 8'h0B, 8'h00, 8'h84};
        vt[1] = '{8'hFF, 8'hFF, 8'hFE, 8'h01};
        vt[2] = '{8'h00, 8'h5A, 8'h00, 8'h00};
        vt[3] = '{8'h01, 8'h80, 8'h00, 8'h80};
        vt[4] = '{8'h03, 8'h04, 8'h00, 8'h0C};
        vt[5] = '{8'h80, 8'h02, 8'h01, 8'h00};

        reset = 1'b0;
        bus.rx_valid = 1'b0; bus.rx_data = '0; bus.tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst tx_valid", int'(bus.tx_valid), 0);
        chk("rst tx_data", int'(bus.tx_data), 0);
        chk("rst busy", int'(bus.busy), 0);
        chk("rst timeout", int'(bus.timeout), 0);
        chk("rst overrun", int'(bus.overrun), 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            frame(vt[i].a, vt[i].b, {vt[i].hi, vt[i].lo}, i % 3, 0,
                  (i == 0) ? 100 : 60, 1'b0, $sformatf("vec%0d", i));
        chk("vec overrun", int'(bus.overrun), 0);

        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            frame(ra, rb, 16'(int'(ra) * int'(rb)), $urandom_range(0, 5), 0,
                  $urandom_range(20, 100), 1'b0, $sformatf("rnd%0d", i));
        end

        frame(8'hA5, 8'h3C, 16'(8'hA5 * 8'h3C), 0, 20, 100, 1'b0, "hold20");

        // Abandoned frame: A only.
        t0 = to_pulses;
        send_byte(8'h12);
        chk("to busy_wait", int'(bus.busy), 1);
        repeat (120) @(negedge clk);
        chk("to pulses", to_pulses - t0, 1);
        chk("to busy", int'(bus.busy), 0);
        chk("to level", int'(bus.timeout), 0);
        frame(8'h03, 8'h04, 16'h000C, 0, 0, 100, 1'b0, "after_to");

        // B in the last cycle before the timeout fires is still taken.
        frame(8'h07, 8'h09, 16'h003F, TO - 1, 0, 100, 1'b0, "edge_gap");

        frame(8'h0C, 8'h0B, 16'h0084, 1, 0, 70, 1'b1, "ovr");
        chk("ovr sticky", int'(bus.overrun), 1);
        frame(8'h05, 8'h06, 16'h001E, 0, 0, 100, 1'b0, "post_ovr");
        chk("ovr still", int'(bus.overrun), 1);

        send_byte(8'h0A);
        send_byte(8'h0B);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid rst tx_valid", int'(bus.tx_valid), 0);
        chk("mid rst tx_data", int'(bus.tx_data), 0);
        chk("mid rst busy", int'(bus.busy), 0);
        chk("mid rst overrun", int'(bus.overrun), 0);
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.tx_valid === 1'b1 || bus.busy === 1'b1) cnt++;
        end
        chk("mid rst quiet", cnt, 0);
        frame(8'h02, 8'h03, 16'h0006, 0, 0, 100, 1'b0, "after_rst");
        chk("after_rst overrun", int'(bus.overrun), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
